// File: rtl/adc_rx_pkg.sv
// Shared definitions for the LVDS ADC receiver: frame-align state encoding,
// counter widths and the default frame patterns per ADC mode.
package adc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_SLIP    = 3'd3,
    ST_VERIFY  = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } frm_align_state_t;

  localparam int unsigned SettleCntW = 4;
  localparam int unsigned MatchCntW  = 8;
  localparam int unsigned LossCntW   = 8;
  localparam int unsigned StatCntW   = 16;

  // Frame word seen on the FCLK lane once aligned, per wiring mode and resolution
  localparam logic [11:0] FrmPat1w12 = 12'hFC0;
  localparam logic [13:0] FrmPat1w14 = 14'h3F80;
  localparam logic [15:0] FrmPat1w16 = 16'hFF00;
  localparam logic [5:0]  FrmPat2w12 = 6'h38;
  localparam logic [6:0]  FrmPat2w14 = 7'h78;
  localparam logic [7:0]  FrmPat2w16 = 8'hF0;

endpackage

// File: rtl/adc_frame_align_fsm.sv
// Frame-clock alignment controller: bitslips the FCLK word until it matches the
// expected pattern, locks, and re-aligns on loss. Optional stats: ADC_FRAME_ALIGN_STATS_EN.
module adc_frame_align_fsm
  import adc_rx_pkg::*;
#(
  parameter int unsigned         FrmWidth   = 8,
  parameter logic [FrmWidth-1:0] FrmPattern = FrmWidth'(FrmPat2w16),
  parameter int unsigned         NumLanes   = 4,
  parameter int unsigned         SlipSettle = 3,
  parameter int unsigned         LockCount  = 16,
  parameter int unsigned         LossCount  = 4
) (
  input  logic                        FrmClk,
  input  logic                        FrmRst,
  input  logic                        FrmEna,
  input  logic                        FrmReAlign,
  input  logic [FrmWidth-1:0]         FrmData,
  input  logic [NumLanes-1:0]         DatLaneEna,
  output logic                        FrmBitslip,
  output logic [NumLanes-1:0]         DatBitslip,
  output logic                        FrmAlignDone,
  output logic                        FrmAlignFail,
  output logic [$clog2(FrmWidth)-1:0] FrmSlipCnt
`ifdef ADC_FRAME_ALIGN_STATS_EN
  ,
  output logic [StatCntW-1:0]         StatSlipTotal,
  output logic [StatCntW-1:0]         StatLossCnt
`endif
);

  localparam int unsigned            SlipW      = $clog2(FrmWidth);
  localparam logic [SlipW-1:0]       SlipMax    = SlipW'(FrmWidth - 1);
  localparam logic [SettleCntW-1:0]  SettleLast = SettleCntW'(SlipSettle - 1);
  localparam logic [MatchCntW-1:0]   LockTarget = MatchCntW'(LockCount);
  localparam logic [LossCntW-1:0]    LossTarget = LossCntW'(LossCount);

  frm_align_state_t        state_q, state_d;
  logic [SettleCntW-1:0]   settle_q, settle_d;
  logic [MatchCntW-1:0]    match_cnt_q, match_cnt_d;
  logic [LossCntW-1:0]     loss_cnt_q, loss_cnt_d;
  logic [SlipW-1:0]        slip_cnt_q, slip_cnt_d;
  logic                    bitslip_q, bitslip_d;
  logic [NumLanes-1:0]     dat_bitslip_q, dat_bitslip_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic                    match_c;

  assign match_c = (FrmData == FrmPattern);

  // Next state and counters; enable and re-align override the normal flow
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    slip_cnt_d  = slip_cnt_q;

    if (!FrmEna) begin
      state_d     = ST_IDLE;
      settle_d    = '0;
      match_cnt_d = '0;
      loss_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else if (FrmReAlign) begin
      state_d     = ST_SETTLE;
      settle_d    = '0;
      match_cnt_d = '0;
      loss_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          settle_d    = '0;
          slip_cnt_d  = '0;
          match_cnt_d = '0;
          loss_cnt_d  = '0;
          state_d     = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q >= SettleLast) begin
            settle_d = '0;
            state_d  = ST_COMPARE;
          end else begin
            settle_d = settle_q + SettleCntW'(1);
          end
        end
        ST_COMPARE, ST_VERIFY: begin
          if (match_c) begin
            if (state_q == ST_COMPARE) begin
              match_cnt_d = MatchCntW'(1);
            end else if (match_cnt_q != '1) begin
              match_cnt_d = match_cnt_q + MatchCntW'(1);
            end
            if (state_q == ST_VERIFY && match_cnt_d >= LockTarget) begin
              state_d    = ST_LOCKED;
              loss_cnt_d = '0;
            end else begin
              state_d = ST_VERIFY;
            end
          end else if (slip_cnt_q == SlipMax) begin
            state_d = ST_FAIL;
          end else begin
            state_d    = ST_SLIP;
            slip_cnt_d = slip_cnt_q + SlipW'(1);
          end
        end
        ST_SLIP: begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
        ST_LOCKED: begin
          if (match_c) begin
            loss_cnt_d = '0;
          end else begin
            if (loss_cnt_q != '1) begin
              loss_cnt_d = loss_cnt_q + LossCntW'(1);
            end
            // Loss: re-compare the current word without resetting the deserialiser
            if (loss_cnt_d >= LossTarget) begin
              state_d     = ST_COMPARE;
              slip_cnt_d  = '0;
              loss_cnt_d  = '0;
              match_cnt_d = '0;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end

    bitslip_d     = (state_d == ST_SLIP);
    dat_bitslip_d = {NumLanes{bitslip_d}} & DatLaneEna;
    done_d        = (state_d == ST_LOCKED);
    fail_d        = (state_d == ST_FAIL);
  end

  always_ff @(posedge FrmClk or posedge FrmRst) begin
    if (FrmRst) begin
      state_q       <= ST_IDLE;
      settle_q      <= '0;
      match_cnt_q   <= '0;
      loss_cnt_q    <= '0;
      slip_cnt_q    <= '0;
      bitslip_q     <= 1'b0;
      dat_bitslip_q <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      match_cnt_q   <= match_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      slip_cnt_q    <= slip_cnt_d;
      bitslip_q     <= bitslip_d;
      dat_bitslip_q <= dat_bitslip_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign FrmBitslip   = bitslip_q;
  assign DatBitslip   = dat_bitslip_q;
  assign FrmAlignDone = done_q;
  assign FrmAlignFail = fail_q;
  assign FrmSlipCnt   = slip_cnt_q;

`ifdef ADC_FRAME_ALIGN_STATS_EN
  logic [StatCntW-1:0] slip_total_q, slip_total_d;
  logic [StatCntW-1:0] loss_evt_q, loss_evt_d;

  // Lifetime counters, saturating, cleared only by reset
  always_comb begin
    slip_total_d = slip_total_q;
    loss_evt_d   = loss_evt_q;
    if (bitslip_d && slip_total_q != '1) begin
      slip_total_d = slip_total_q + StatCntW'(1);
    end
    if (FrmEna && !FrmReAlign && state_q == ST_LOCKED && state_d == ST_COMPARE
        && loss_evt_q != '1) begin
      loss_evt_d = loss_evt_q + StatCntW'(1);
    end
  end

  always_ff @(posedge FrmClk or posedge FrmRst) begin
    if (FrmRst) begin
      slip_total_q <= '0;
      loss_evt_q   <= '0;
    end else begin
      slip_total_q <= slip_total_d;
      loss_evt_q   <= loss_evt_d;
    end
  end

  assign StatSlipTotal = slip_total_q;
  assign StatLossCnt   = loss_evt_q;
`endif

endmodule

// File: tb/tb_adc_frame_align_fsm.sv
// Self-checking bench for adc_frame_align_fsm; models a deserialiser whose word
// rotates left by one bit two cycles after each bitslip pulse.
module tb_adc_frame_align_fsm;

  logic       FrmClk = 1'b0;
  logic       FrmRst;
  logic       FrmEna;
  logic       FrmReAlign;
  logic [7:0] FrmData;
  logic [3:0] DatLaneEna;
  logic       FrmBitslip;
  logic [3:0] DatBitslip;
  logic       FrmAlignDone;
  logic       FrmAlignFail;
  logic [2:0] FrmSlipCnt;
`ifdef ADC_FRAME_ALIGN_STATS_EN
  logic [15:0] StatSlipTotal;
  logic [15:0] StatLossCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] pipe;

  typedef struct {
    logic [7:0] data;
    logic [3:0] lanes;
    int         slips;
    logic [2:0] cnt;
    logic       done;
    logic       fail;
  } vec_t;

  vec_t vecs[5];

  always #5 FrmClk = ~FrmClk;

  adc_frame_align_fsm dut (
    .FrmClk       (FrmClk),
    .FrmRst       (FrmRst),
    .FrmEna       (FrmEna),
    .FrmReAlign   (FrmReAlign),
    .FrmData      (FrmData),
    .DatLaneEna   (DatLaneEna),
    .FrmBitslip   (FrmBitslip),
    .DatBitslip   (DatBitslip),
    .FrmAlignDone (FrmAlignDone),
    .FrmAlignFail (FrmAlignFail),
    .FrmSlipCnt   (FrmSlipCnt)
`ifdef ADC_FRAME_ALIGN_STATS_EN
    ,
    .StatSlipTotal(StatSlipTotal),
    .StatLossCnt  (StatLossCnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; sample outputs 1 time unit after the edge, then advance the deserialiser model
  task automatic tick();
    @(posedge FrmClk);
    #1;
    pipe = {pipe[1:0], FrmBitslip};
    if (pipe[2]) FrmData = {FrmData[6:0], FrmData[7]};
  endtask

  task automatic do_reset();
    FrmRst     = 1'b1;
    FrmEna     = 1'b0;
    FrmReAlign = 1'b0;
    FrmData    = 8'h00;
    DatLaneEna = 4'hF;
    pipe       = 3'b000;
    tick();
    tick();
    FrmRst = 1'b0;
    tick();
    pipe = 3'b000;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int c;
    c = 0;
    while (!FrmAlignDone && c < max_cyc) begin
      tick();
      c++;
    end
    chk(name, 32'(FrmAlignDone), 32'd1);
  endtask

  initial begin
    int pulses;
    int lane_cnt[4];
    int min_gap;
    int last;
    logic hold_ok;
    logic found;

    vecs[0] = '{8'hF0, 4'b1111, 0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{8'h1E, 4'b1010, 3, 3'd3, 1'b1, 1'b0};
    vecs[2] = '{8'h78, 4'b0101, 1, 3'd1, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 4'b0011, 4, 3'd4, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 4'b1111, 7, 3'd7, 1'b0, 1'b1};

    // Reset values
    do_reset();
    FrmRst = 1'b1;
    #2;
    chk("rst_bitslip", 32'(FrmBitslip), 32'd0);
    chk("rst_dat_bitslip", 32'(DatBitslip), 32'd0);
    chk("rst_done", 32'(FrmAlignDone), 32'd0);
    chk("rst_fail", 32'(FrmAlignFail), 32'd0);
    chk("rst_slipcnt", 32'(FrmSlipCnt), 32'd0);
    FrmRst = 1'b0;

    // Table-driven alignment scenarios
    for (int i = 0; i < 5; i++) begin
      do_reset();
      FrmData    = vecs[i].data;
      DatLaneEna = vecs[i].lanes;
      FrmEna     = 1'b1;
      pulses     = 0;
      min_gap    = 1000;
      last       = -1000;
      for (int l = 0; l < 4; l++) lane_cnt[l] = 0;
      for (int c = 0; c < 120; c++) begin
        tick();
        if (FrmBitslip) begin
          pulses++;
          if (c - last < min_gap) min_gap = c - last;
          last = c;
        end
        for (int l = 0; l < 4; l++) if (DatBitslip[l]) lane_cnt[l]++;
      end
      chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].slips));
      chk($sformatf("v%0d_slipcnt", i), 32'(FrmSlipCnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_done", i), 32'(FrmAlignDone), 32'(vecs[i].done));
      chk($sformatf("v%0d_fail", i), 32'(FrmAlignFail), 32'(vecs[i].fail));
      for (int l = 0; l < 4; l++)
        chk($sformatf("v%0d_lane%0d", i, l), 32'(lane_cnt[l]),
            vecs[i].lanes[l] ? 32'(vecs[i].slips) : 32'd0);
      if (vecs[i].slips >= 2)
        chk($sformatf("v%0d_gap_ge4", i), 32'(min_gap >= 4), 32'd1);
    end

    // Lock latency from enable with an aligned word: 20 cycles
    do_reset();
    FrmData = 8'hF0;
    FrmEna  = 1'b1;
    repeat (19) tick();
    chk("lat_19_not_done", 32'(FrmAlignDone), 32'd0);
    tick();
    chk("lat_20_done", 32'(FrmAlignDone), 32'd1);
    chk("lat_slipcnt", 32'(FrmSlipCnt), 32'd0);

    // Fail then re-align
    do_reset();
    FrmData = 8'hAA;
    FrmEna  = 1'b1;
    repeat (80) tick();
    chk("fail_set", 32'(FrmAlignFail), 32'd1);
    chk("fail_not_done", 32'(FrmAlignDone), 32'd0);
    FrmReAlign = 1'b1;
    tick();
    FrmReAlign = 1'b0;
    chk("realign_clr_fail", 32'(FrmAlignFail), 32'd0);
    chk("realign_clr_slipcnt", 32'(FrmSlipCnt), 32'd0);
    FrmData = 8'hF0;
    wait_done("realign_lock", 40);

    // Mismatch tolerance and loss of lock
    do_reset();
    FrmData = 8'hF0;
    FrmEna  = 1'b1;
    repeat (25) tick();
    chk("loss_pre_lock", 32'(FrmAlignDone), 32'd1);
    hold_ok = 1'b1;
    FrmData = 8'h00;
    repeat (3) begin tick(); hold_ok &= FrmAlignDone; end
    FrmData = 8'hF0;
    tick();
    hold_ok &= FrmAlignDone;
    FrmData = 8'h00;
    repeat (3) begin tick(); hold_ok &= FrmAlignDone; end
    FrmData = 8'hF0;
    tick();
    hold_ok &= FrmAlignDone;
    chk("loss_tolerate", 32'(hold_ok), 32'd1);
    FrmData = 8'h00;
    repeat (3) tick();
    chk("loss_3_still_locked", 32'(FrmAlignDone), 32'd1);
    tick();
    chk("loss_4_drop", 32'(FrmAlignDone), 32'd0);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    chk("stat_loss_cnt", 32'(StatLossCnt), 32'd1);
    chk("stat_slip_total", 32'(StatSlipTotal), 32'd0);
`endif
    FrmData = 8'hF0;
    wait_done("loss_relock", 40);
    chk("loss_relock_slipcnt", 32'(FrmSlipCnt), 32'd0);

    // Asynchronous reset while settling after the second slip
    do_reset();
    FrmData    = 8'h1E;
    DatLaneEna = 4'b1010;
    FrmEna     = 1'b1;
    found      = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (FrmBitslip && FrmSlipCnt == 3'd2) found = 1'b1;
    end
    chk("mid_found_slip2", 32'(found), 32'd1);
    tick();
    chk("mid_settle_slipcnt", 32'(FrmSlipCnt), 32'd2);
    #2;
    FrmRst = 1'b1;
    #1;
    chk("mid_rst_slipcnt", 32'(FrmSlipCnt), 32'd0);
    chk("mid_rst_outs", 32'({FrmBitslip, DatBitslip, FrmAlignDone, FrmAlignFail}), 32'd0);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    chk("mid_rst_stats", 32'({StatSlipTotal, StatLossCnt}), 32'd0);
`endif
    #1;
    FrmRst = 1'b0;
    wait_done("mid_relock", 80);
    chk("mid_relock_fail", 32'(FrmAlignFail), 32'd0);

    // Enable low beats re-align in the same cycle
    do_reset();
    FrmData = 8'hF0;
    FrmEna  = 1'b1;
    repeat (25) tick();
    chk("prio_pre_lock", 32'(FrmAlignDone), 32'd1);
    FrmEna     = 1'b0;
    FrmReAlign = 1'b1;
    tick();
    FrmEna     = 1'b1;
    FrmReAlign = 1'b0;
    chk("prio_done_clr", 32'(FrmAlignDone), 32'd0);
    repeat (19) tick();
    chk("prio_idle_19", 32'(FrmAlignDone), 32'd0);
    tick();
    chk("prio_idle_20", 32'(FrmAlignDone), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
